// File: rtl/mother_board_if.sv
// Board-level signal bundle for mother_board: RAM2 address/controls, UART strobes and status,
// RAM1 controls, VGA pins, debug LEDs and the two board strobes (clkHand, clkUART).
// Purely wiring. Zero latency. No flow control. The tristate buses (memDataBus, ram1DataBus)
// stay as plain inout ports on the top so tristate resolution is explicit at the pins.
// Port summary:
//   slave  (the board logic): in clkHand/clkUART/tbre/tsre/dataReady, out everything else
//   master (the environment): the mirror image
interface mother_board_if;
    logic        clkHand;
    logic        clkUART;
    logic [17:0] memAddrBus;
    logic        memRead;
    logic        memWrite;
    logic        memEnable;
    logic        vgaHs;
    logic        vgaVs;
    logic [2:0]  vgaR;
    logic [2:0]  vgaG;
    logic [2:0]  vgaB;
    logic [15:0] leddebug;
    logic        tbre;
    logic        tsre;
    logic        dataReady;
    logic        rdn;
    logic        wrn;
    logic        ram1Oe;
    logic        ram1We;
    logic        ram1En;

    modport slave (
        input  clkHand, clkUART, tbre, tsre, dataReady,
        output memAddrBus, memRead, memWrite, memEnable,
        output vgaHs, vgaVs, vgaR, vgaG, vgaB, leddebug,
        output rdn, wrn, ram1Oe, ram1We, ram1En
    );

    modport master (
        output clkHand, clkUART, tbre, tsre, dataReady,
        input  memAddrBus, memRead, memWrite, memEnable,
        input  vgaHs, vgaVs, vgaR, vgaG, vgaB, leddebug,
        input  rdn, wrn, ram1Oe, ram1We, ram1En
    );
endinterface

// File: rtl/mother_board.sv
// Board glue: single-step fetch engine (RAM2 -> IR -> LEDs -> UART tx), UART rx reloads PC,
// optional VGA timing generator. Fetch takes 2 clk; tx/rx strobes last WR_TICKS/RD_TICKS clkUART ticks.
// Backpressure: tx waits on tbre then tsre, rx waits for dataReady to drop; step edges seen outside IDLE are dropped.
// Ports:
//   clk, rst       sole clock, synchronous active-high reset
//   bus (slave)    RAM2 addr/controls, UART strobes/status, RAM1 controls, VGA pins, LEDs, strobes
//   memDataBus     RAM2 data, only ever read here
//   ram1DataBus    UART data, driven with IR[7:0] only while wrn is low
// Optional feature: define MB_VGA_EN to build the VGA counters and colour path; otherwise the
// syncs sit at 1 and the colour pins at 0.
module mother_board #(
    parameter logic [17:0] PC_RESET = 18'h00000,
    parameter int unsigned WR_TICKS = 2,
    parameter int unsigned RD_TICKS = 2
`ifdef MB_VGA_EN
    ,
    parameter int unsigned PIX_DIV  = 2
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mother_board_if.slave bus,
    inout  wire  [15:0]   memDataBus,
    inout  wire  [7:0]    ram1DataBus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_TX_DRV,
        S_TX_WAIT_TBRE,
        S_TX_WAIT_TSRE,
        S_RX_PULSE,
        S_RX_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_hand_sync;
    logic [2:0]  r_uart_sync;
    logic [17:0] r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_tick_cnt;

    logic        w_step;
    logic        w_tick;
    logic        w_tx_done;
    logic        w_rx_done;

    logic        w_mem_ce_n;
    logic        w_mem_oe_n;
    logic        w_wrn;
    logic        w_rdn;
    logic        w_tx_oe;

    // Both strobes are asynchronous to clk: two flops to synchronise, a third to find the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hand_sync <= 3'b000;
            r_uart_sync <= 3'b000;
        end else begin
            r_hand_sync <= {r_hand_sync[1:0], bus.clkHand};
            r_uart_sync <= {r_uart_sync[1:0], bus.clkUART};
        end
    end

    assign w_step = r_hand_sync[1] & ~r_hand_sync[2];
    assign w_tick = r_uart_sync[1] & ~r_uart_sync[2];

    // The tick that completes the strobe is the one that arrives when WR/RD_TICKS-1 are already counted.
    assign w_tx_done = (r_state == S_TX_DRV)   && w_tick && (r_tick_cnt == 8'(WR_TICKS - 1));
    assign w_rx_done = (r_state == S_RX_PULSE) && w_tick && (r_tick_cnt == 8'(RD_TICKS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A received byte takes priority over a step arriving in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.dataReady) begin
                    w_state_nxt = S_RX_PULSE;
                end else if (w_step) begin
                    w_state_nxt = S_FETCH1;
                end
            end
            S_FETCH1:       w_state_nxt = S_FETCH2;
            S_FETCH2:       w_state_nxt = S_TX_DRV;
            S_TX_DRV:       if (w_tx_done) w_state_nxt = S_TX_WAIT_TBRE;
            S_TX_WAIT_TBRE: if (bus.tbre)  w_state_nxt = S_TX_WAIT_TSRE;
            S_TX_WAIT_TSRE: if (bus.tsre)  w_state_nxt = S_IDLE;
            S_RX_PULSE:     if (w_rx_done) w_state_nxt = S_RX_DONE;
            S_RX_DONE:      if (!bus.dataReady) w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode, straight from the state register so reset clears every strobe on the next edge.
    always_comb begin
        w_mem_ce_n = 1'b1;
        w_mem_oe_n = 1'b1;
        w_wrn      = 1'b1;
        w_rdn      = 1'b1;
        w_tx_oe    = 1'b0;
        case (r_state)
            S_FETCH1, S_FETCH2: begin
                w_mem_ce_n = 1'b0;
                w_mem_oe_n = 1'b0;
            end
            S_TX_DRV: begin
                w_wrn   = 1'b0;
                w_tx_oe = 1'b1;
            end
            S_RX_PULSE: begin
                w_rdn = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath: PC, IR and the clkUART tick counter (cleared on every state change).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_RESET;
            r_ir       <= 16'h0000;
            r_tick_cnt <= 8'd0;
        end else begin
            if (r_state == S_FETCH2) begin
                r_ir <= memDataBus;
                r_pc <= r_pc + 18'd1;
            end else if (w_rx_done) begin
                r_pc <= {10'b0, ram1DataBus};
            end

            if (w_state_nxt != r_state) begin
                r_tick_cnt <= 8'd0;
            end else if (w_tick && ((r_state == S_TX_DRV) || (r_state == S_RX_PULSE))) begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end
        end
    end

    assign ram1DataBus    = w_tx_oe ? r_ir[7:0] : 8'bz;

    assign bus.memAddrBus = r_pc;
    assign bus.memEnable  = w_mem_ce_n;
    assign bus.memRead    = w_mem_oe_n;
    assign bus.memWrite   = 1'b1;
    assign bus.wrn        = w_wrn;
    assign bus.rdn        = w_rdn;
    assign bus.ram1Oe     = 1'b1;
    assign bus.ram1We     = 1'b1;
    assign bus.ram1En     = 1'b1;
    assign bus.leddebug   = r_ir;

`ifdef MB_VGA_EN
    logic [7:0] r_pix_cnt;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       r_hs;
    logic       r_vs;
    logic [2:0] r_red;
    logic [2:0] r_grn;
    logic [2:0] r_blu;
    logic       w_pix_en;

    assign w_pix_en = (r_pix_cnt == 8'(PIX_DIV - 1));

    // 800 x 525 frame; syncs and colour are registered from the current counter values,
    // so all outputs share the same one-clock lag and pulse widths are preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt <= 8'd0;
            r_hcnt    <= 10'd0;
            r_vcnt    <= 10'd0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_red     <= 3'd0;
            r_grn     <= 3'd0;
            r_blu     <= 3'd0;
        end else begin
            r_pix_cnt <= w_pix_en ? 8'd0 : r_pix_cnt + 8'd1;
            if (w_pix_en) begin
                if (r_hcnt == 10'd799) begin
                    r_hcnt <= 10'd0;
                    r_vcnt <= (r_vcnt == 10'd524) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
            end
            r_hs <= !((r_hcnt >= 10'd656) && (r_hcnt <= 10'd751));
            r_vs <= !((r_vcnt >= 10'd490) && (r_vcnt <= 10'd491));
            if ((r_hcnt < 10'd640) && (r_vcnt < 10'd480)) begin
                r_red <= r_ir[8:6];
                r_grn <= r_ir[5:3];
                r_blu <= r_ir[2:0];
            end else begin
                r_red <= 3'd0;
                r_grn <= 3'd0;
                r_blu <= 3'd0;
            end
        end
    end

    assign bus.vgaHs = r_hs;
    assign bus.vgaVs = r_vs;
    assign bus.vgaR  = r_red;
    assign bus.vgaG  = r_grn;
    assign bus.vgaB  = r_blu;
`else
    assign bus.vgaHs = 1'b1;
    assign bus.vgaVs = 1'b1;
    assign bus.vgaR  = 3'd0;
    assign bus.vgaG  = 3'd0;
    assign bus.vgaB  = 3'd0;
`endif

endmodule

// File: tb/tb_mother_board.sv
// Bench for mother_board: reference model of PC/IR, RAM2 content function, UART tick driver.
// Table of rx-load/step vectors, hand-written corner sequences, then a random op stream.
module tb_mother_board;

    localparam int unsigned WR_TICKS = 2;
    localparam int unsigned RD_TICKS = 2;
    localparam int unsigned PIX_DIV  = 2;

    logic clk;
    logic rst;
    wire  [15:0] memDataBus;
    wire  [7:0]  ram1DataBus;
    logic [7:0]  tb_rx_val;

    mother_board_if ifc ();

    mother_board dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc),
        .memDataBus (memDataBus),
        .ram1DataBus(ram1DataBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM2 content is a fixed function of the address.
    function automatic logic [15:0] mem_word(input logic [17:0] a);
        return 16'h1044 ^ {a[17:10], a[7:0]};
    endfunction

    assign memDataBus = mem_word(ifc.memAddrBus);

    // Undriven UART bus reads back as 8'hFF; the UART side drives only while rdn is low.
    pullup (ram1DataBus);
    assign ram1DataBus = (ifc.rdn == 1'b0) ? tb_rx_val : 8'bz;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [17:0] m_pc;
    logic [15:0] m_ir;
    logic [17:0] last_addr;

    typedef struct {
        logic [7:0]  rx;
        int          nsteps;
        logic [17:0] exp_addr;
        logic [15:0] exp_led;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return ifc.memRead;
            1:       return ifc.wrn;
            default: return ifc.rdn;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input logic val);
        int k;
        k = 0;
        while ((get_sig(which) !== val) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        if (get_sig(which) !== val) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: signal=%0b, expected %0b", name, get_sig(which), val);
        end
    endtask

    task automatic pulse_tick();
        ifc.clkUART = 1'b1;
        repeat (4) @(negedge clk);
        ifc.clkUART = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One manual step with full checking; with hold=1 the caller keeps tbre/tsre low.
    task automatic do_step(input bit hold);
        logic [17:0] ea;
        logic [15:0] ew;
        ea = m_pc;
        ew = mem_word(m_pc);
        @(negedge clk);
        ifc.clkHand = 1'b1;
        wait_for("fetch_start", 0, 1'b0);
        chk("fetch_addr", 32'(ifc.memAddrBus), 32'(ea));
        chk("fetch_ce", 32'(ifc.memEnable), 32'd0);
        last_addr = ifc.memAddrBus;
        wait_for("tx_start", 1, 1'b0);
        ifc.clkHand = 1'b0;
        chk("tx_led", 32'(ifc.leddebug), 32'(ew));
        chk("tx_byte", 32'(ram1DataBus), 32'(ew[7:0]));
        chk("tx_oe_off", 32'(ifc.memRead), 32'd1);
        for (int k = 1; k <= int'(WR_TICKS); k++) begin
            pulse_tick();
            chk("wrn_ticks", 32'(ifc.wrn), (k < int'(WR_TICKS)) ? 32'd0 : 32'd1);
        end
        chk("tx_bus_z", 32'(ram1DataBus), 32'hFF);
        m_ir = ew;
        m_pc = ea + 18'd1;
        if (!hold) repeat (4) @(negedge clk);
    endtask

    task automatic do_rx(input logic [7:0] b);
        @(negedge clk);
        tb_rx_val     = b;
        ifc.dataReady = 1'b1;
        wait_for("rx_start", 2, 1'b0);
        chk("rx_no_fetch", 32'(ifc.memRead), 32'd1);
        for (int k = 1; k <= int'(RD_TICKS); k++) begin
            pulse_tick();
            chk("rdn_ticks", 32'(ifc.rdn), (k < int'(RD_TICKS)) ? 32'd0 : 32'd1);
        end
        ifc.dataReady = 1'b0;
        repeat (4) @(negedge clk);
        m_pc = {10'b0, b};
    endtask

    // Counts cycles in which a fetch is active over a window.
    task automatic count_fetch(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ifc.memRead == 1'b0) seen++;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0] = '{rx: 8'h20, nsteps: 1, exp_addr: 18'h00020, exp_led: 16'h1064};
        vecs[1] = '{rx: 8'hFF, nsteps: 2, exp_addr: 18'h00100, exp_led: 16'h1044};
        vecs[2] = '{rx: 8'h7F, nsteps: 3, exp_addr: 18'h00081, exp_led: 16'h10C5};
        vecs[3] = '{rx: 8'h00, nsteps: 1, exp_addr: 18'h00000, exp_led: 16'h1044};
        vecs[4] = '{rx: 8'hA5, nsteps: 1, exp_addr: 18'h000A5, exp_led: 16'h10E1};

        rst = 1'b1;
        tb_rx_val     = 8'h00;
        ifc.clkHand   = 1'b0;
        ifc.clkUART   = 1'b0;
        ifc.tbre      = 1'b1;
        ifc.tsre      = 1'b1;
        ifc.dataReady = 1'b0;
        m_pc = 18'h00000;
        m_ir = 16'h0000;
        last_addr = 18'h0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_addr", 32'(ifc.memAddrBus), 32'h0);
        chk("rst_led", 32'(ifc.leddebug), 32'h0);
        chk("rst_mem_ctl", 32'({ifc.memEnable, ifc.memRead, ifc.memWrite}), 32'h7);
        chk("rst_uart", 32'({ifc.rdn, ifc.wrn}), 32'h3);
        chk("rst_ram1", 32'({ifc.ram1Oe, ifc.ram1We, ifc.ram1En}), 32'h7);
        chk("rst_bus_z", 32'(ram1DataBus), 32'hFF);
        chk("rst_sync", 32'({ifc.vgaHs, ifc.vgaVs}), 32'h3);
        chk("rst_colour", 32'({ifc.vgaR, ifc.vgaG, ifc.vgaB}), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First fetch: address 0, word 1044, low byte 44 on the UART, PC -> 1
        do_step(1'b0);
        chk("first_led", 32'(ifc.leddebug), 32'h1044);
        chk("first_pc", 32'(ifc.memAddrBus), 32'h1);

        // TX handshake stall: steps while waiting on tbre/tsre are dropped
        ifc.tbre = 1'b0;
        ifc.tsre = 1'b0;
        do_step(1'b1);
        @(negedge clk);
        ifc.clkHand = 1'b1;
        count_fetch(10, seen);
        ifc.clkHand = 1'b0;
        chk("stall_tbre_drop", 32'(seen), 32'd0);
        ifc.tbre = 1'b1;
        repeat (4) @(negedge clk);
        ifc.clkHand = 1'b1;
        count_fetch(10, seen);
        ifc.clkHand = 1'b0;
        chk("stall_tsre_drop", 32'(seen), 32'd0);
        ifc.tsre = 1'b1;
        count_fetch(20, seen);
        chk("no_queued_step", 32'(seen), 32'd0);
        do_step(1'b0);

        // RX reload then fetch from the received address
        do_rx(8'h20);
        do_step(1'b0);
        chk("rx_fetch_addr", 32'(last_addr), 32'h00020);

        // Table of rx loads followed by steps
        for (int i = 0; i < 5; i++) begin
            do_rx(vecs[i].rx);
            for (int s = 0; s < vecs[i].nsteps; s++) do_step(1'b0);
            chk("vec_addr", 32'(last_addr), 32'(vecs[i].exp_addr));
            chk("vec_led", 32'(ifc.leddebug), 32'(vecs[i].exp_led));
        end

        // Step and byte arriving in the same cycle: the byte wins, the step is lost
        @(negedge clk);
        ifc.clkHand = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tb_rx_val     = 8'h3C;
        ifc.dataReady = 1'b1;
        @(negedge clk);
        chk("rx_wins_rdn", 32'(ifc.rdn), 32'd0);
        chk("rx_wins_nofetch", 32'(ifc.memRead), 32'd1);
        ifc.clkHand = 1'b0;
        for (int k = 0; k < int'(RD_TICKS); k++) pulse_tick();
        ifc.dataReady = 1'b0;
        m_pc = 18'h0003C;
        count_fetch(20, seen);
        chk("rx_wins_drop", 32'(seen), 32'd0);
        do_step(1'b0);

        // PC wrap 3FFFF -> 0
        @(negedge clk);
        force dut.r_pc = 18'h3FFFF;
        @(negedge clk);
        release dut.r_pc;
        m_pc = 18'h3FFFF;
        do_step(1'b0);
        chk("wrap_addr", 32'(last_addr), 32'h3FFFF);
        chk("wrap_pc", 32'(ifc.memAddrBus), 32'h0);
        do_step(1'b0);

        // Random op stream against the model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) < 3) do_step(1'b0);
            else do_rx(8'($urandom_range(0, 255)));
            chk("rand_led", 32'(ifc.leddebug), 32'(m_ir));
            chk("rand_pc", 32'(ifc.memAddrBus), 32'(m_pc));
        end

        // Reset in the middle of a transmit
        @(negedge clk);
        ifc.clkHand = 1'b1;
        wait_for("midtx_start", 1, 1'b0);
        ifc.clkHand = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midtx_wrn", 32'(ifc.wrn), 32'd1);
        chk("midtx_bus_z", 32'(ram1DataBus), 32'hFF);
        chk("midtx_led", 32'(ifc.leddebug), 32'h0);
        chk("midtx_addr", 32'(ifc.memAddrBus), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 18'h0;
        m_ir = 16'h0;
        repeat (3) @(negedge clk);
        do_step(1'b0);

`ifdef MB_VGA_EN
        begin
            int lo;
            int per;
            int k;
            k = 0;
            while (ifc.vgaHs !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
            while (ifc.vgaHs !== 1'b0 && k < 4000) begin @(negedge clk); k++; end
            lo = 0;
            while (ifc.vgaHs === 1'b0 && k < 8000) begin @(negedge clk); k++; lo++; end
            per = lo;
            while (ifc.vgaHs === 1'b1 && k < 8000) begin @(negedge clk); k++; per++; end
            chk("vga_hs_low", 32'(lo), 32'(96 * PIX_DIV));
            chk("vga_hs_period", 32'(per), 32'(800 * PIX_DIV));
        end
`else
        chk("vga_off_sync", 32'({ifc.vgaHs, ifc.vgaVs}), 32'h3);
        chk("vga_off_colour", 32'({ifc.vgaR, ifc.vgaG, ifc.vgaB}), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
